multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle FSM sequencing the 16-bit RISC datapath (register file + ALU + immediate unit).
//  Consumes the latched instruction word (IR output), ALU flags and the memory handshake.
//  Produces every datapath enable and select per cycle: fetch, decode, execute, memory, write-back.
//  Sits directly upstream of the RF+ALU datapath and drives all of its control inputs.
// PARAMETERS
//  MEM_WAIT_MAX  15  max cycles Mem_Req may wait for Mem_Ack before entering HALT (fault)
//  WAIT_CNT_W    4   width of the memory-wait counter
// PORTS
//  clk           in   1   single system clock, rising edge
//  rst           in   1   synchronous, active-high reset
//  Instr         in   16  IR contents; opcode=[15:11], Rd=[10:8], Rm=[7:5], Rn=[4:2], imm5=[4:0], imm8=[7:0]
//  NZVC          in   4   ALU flags {N,Z,V,C}, valid in the EXEC cycle
//  Mem_Ack       in   1   memory completes the access this cycle
//  Mem_Req       out  1   memory access request; held until Mem_Ack
//  Mem_Write_en  out  1   qualifies Mem_Req as a write (data = RF read port B)
//  Addr_Sel      out  1   0: address=PC, 1: address=ALU_Out
//  IR_Write_en   out  1   load IR from memory data
//  PC_Write_en   out  1   PC update strobe
//  PC_Sel        out  1   0: PC+1, 1: PC+sext(imm8)
//  RF_Write_en   out  1   RF write strobe
//  WB_Sel        out  2   write data: 00 ALU_Out, 01 mem data, 10 Imm_Out, 11 reserved (never driven)
//  Rd_to_RF      out  3   RF write address
//  Rm_Rd_to_RF   out  3   RF read port A address
//  Rn_to_RF      out  3   RF read port B address
//  ALU_B_Sel     out  2   00 RF port B, 01 Imm_Out
//  ALU_Control   out  1   0 add, 1 sub
//  ALUOut_CE     out  1   ALU output register enable
//  Imm_Sel       out  2   00 sext imm5, 01 sext imm8, 10 zext imm8, 11 {imm8,Rd[7:0]}
//  Halted        out  1   1 in HALT state
// BEHAVIOUR
//  - Outputs are decoded combinationally from state_q and Instr. All outputs are 0 while rst=1.
//  - rst: state_q<=FETCH, flags_q<=0, wait_cnt<=0. Reset mid-access drops Mem_Req the same cycle.
//  - States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT.
//  - FETCH: Mem_Req=1, Addr_Sel=0. On Mem_Ack: IR_Write_en=1, PC_Write_en=1, PC_Sel=0, go to DECODE.
//  - DECODE: RF reads issued (Rm_Rd_to_RF, Rn_to_RF). Branch -> BRANCH, HALT op -> HALT,
//    undefined opcode -> FETCH (NOP), else -> EXEC.
//  - Opcodes (5b): 00000 ADD, 00001 SUB, 00010 ADDI imm5, 00011 SUBI imm5, 00100 ADDI8 Rd+=sext,
//    00101 ADDU8 Rd+=zext, 00110 MOVT Rd={imm8,Rd[7:0]}, 00111 CMP Rm-Rn, 01000 LDR [Rm+imm5],
//    01001 STR [Rm+imm5], 10000 B, 10001 BEQ(Z), 10010 BNE(!Z), 10011 BLT(N^V), 11111 HALT.
//  - ADDI8/ADDU8/MOVT: Rm_Rd_to_RF=Rd.
//  - STR: Rn_to_RF=Rd so store data appears on port B.
//  - EXEC: ALUOut_CE=1.
//    - ALU/CMP ops: flags_q<=NZVC. ALU ops -> WB, CMP -> FETCH.
//    - LDR/STR: add with imm5 -> MEM. MOVT: no ALU op, -> WB.
//  - MEM: Mem_Req=1, Addr_Sel=1, Mem_Write_en=STR. On Mem_Ack: STR -> FETCH, LDR -> WB (data latched).
//  - WB: RF_Write_en=1, Rd_to_RF=Rd, WB_Sel per op. -> FETCH.
//  - BRANCH: PC_Write_en=PC_Sel=(taken), Imm_Sel=01. -> FETCH. Condition uses flags_q, never live NZVC.
//  - Latency: ALU op 4 cycles, CMP 3, STR 4, LDR 5, branch 3, each plus memory wait cycles.
//  - Memory wait: wait_cnt increments each Mem_Req cycle without Mem_Ack and clears on Ack/state exit.
//    Reaching MEM_WAIT_MAX -> HALT.
//  - HALT is absorbing until rst: Halted=1, all other outputs 0.
// STRUCTURE
//  - Shared package mcu_pkg: opcode localparams, state encoding (3b), WB_Sel/Imm_Sel/ALU_B_Sel codes,
//    Instr field bit positions.
//  - One sub-module: instr_decoder (combinational; Instr -> op class, Imm_Sel, WB_Sel, ALU_Control).
// TESTING
//  1. rst 2 cycles, Mem_Ack tied 1 -> outputs 0 during rst; FETCH asserts Mem_Req, IR_Write_en, PC_Write_en.
//  2. Instr=16'h0174 (ADD R1,R3,R5), ack immediate -> exactly 4 cycles.
//     EXEC: ALU_Control=0, ALU_B_Sel=00, ALUOut_CE=1. WB: Rd_to_RF=001, WB_Sel=00.
//  3. CMP with NZVC=4'b0100 then BEQ imm8=8'hFE -> BRANCH asserts PC_Sel=1, PC_Write_en=1.
//     Repeat with NZVC=0 -> PC_Write_en=0.
//  4. LDR with Mem_Ack delayed 3 cycles in MEM -> Mem_Req held 4 cycles, Addr_Sel=1.
//     Then WB with WB_Sel=01, 5+3 cycles total.
//  5. Mem_Ack held 0 in FETCH -> HALT after MEM_WAIT_MAX=15 cycles, Halted=1; rst -> FETCH.
//  6. Opcode 01111 (undefined) -> DECODE->FETCH, RF_Write_en never asserts; rst during MEM -> next cycle FETCH.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM state encoding,
// datapath select codes and instruction field positions.
package mcu_pkg;

    localparam int OPC_W   = 5;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 11;
    localparam int RD_MSB  = 10;
    localparam int RD_LSB  = 8;
    localparam int RM_MSB  = 7;
    localparam int RM_LSB  = 5;
    localparam int RN_MSB  = 4;
    localparam int RN_LSB  = 2;

    localparam logic [OPC_W-1:0] OP_ADD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB   = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ADDI  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_SUBI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADDI8 = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDU8 = 5'b00101;
    localparam logic [OPC_W-1:0] OP_MOVT  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_CMP   = 5'b00111;
    localparam logic [OPC_W-1:0] OP_LDR   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_STR   = 5'b01001;
    localparam logic [OPC_W-1:0] OP_B     = 5'b10000;
    localparam logic [OPC_W-1:0] OP_BEQ   = 5'b10001;
    localparam logic [OPC_W-1:0] OP_BNE   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_BLT   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_HALT  = 5'b11111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU   = 3'd0,
        CLS_CMP   = 3'd1,
        CLS_MOVT  = 3'd2,
        CLS_LDR   = 3'd3,
        CLS_STR   = 3'd4,
        CLS_BR    = 3'd5,
        CLS_HALT  = 3'd6,
        CLS_UNDEF = 3'd7
    } op_class_t;

    localparam logic [1:0] WB_ALU    = 2'b00;
    localparam logic [1:0] WB_MEM    = 2'b01;
    localparam logic [1:0] WB_IMM    = 2'b10;

    localparam logic [1:0] IMM_SEXT5 = 2'b00;
    localparam logic [1:0] IMM_SEXT8 = 2'b01;
    localparam logic [1:0] IMM_ZEXT8 = 2'b10;
    localparam logic [1:0] IMM_MOVT  = 2'b11;

    localparam logic [1:0] ALUB_RF   = 2'b00;
    localparam logic [1:0] ALUB_IMM  = 2'b01;

    // Branch condition codes coincide with the low two bits of the branch opcodes.
    localparam logic [1:0] BR_ALWAYS = 2'b00;
    localparam logic [1:0] BR_EQ     = 2'b01;
    localparam logic [1:0] BR_NE     = 2'b10;
    localparam logic [1:0] BR_LT     = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/multicycle_control_unit_instr_decoder.sv
// Combinational opcode decoder: classifies the instruction and produces the
// per-instruction datapath selects used by the sequencing FSM.
module instr_decoder
    import mcu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output op_class_t        op_class,
    output logic [1:0]       imm_sel,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_b_sel,
    output logic             alu_control,
    output logic             rm_from_rd,
    output logic             rn_from_rd,
    output logic [1:0]       br_cond
);

    always_comb begin
        op_class    = CLS_UNDEF;
        imm_sel     = IMM_SEXT5;
        wb_sel      = WB_ALU;
        alu_b_sel   = ALUB_RF;
        alu_control = 1'b0;
        rm_from_rd  = 1'b0;
        rn_from_rd  = 1'b0;
        br_cond     = opcode[1:0];
        case (opcode)
            OP_ADD:  op_class = CLS_ALU;
            OP_SUB: begin
                op_class    = CLS_ALU;
                alu_control = 1'b1;
            end
            OP_ADDI: begin
                op_class  = CLS_ALU;
                alu_b_sel = ALUB_IMM;
            end
            OP_SUBI: begin
                op_class    = CLS_ALU;
                alu_b_sel   = ALUB_IMM;
                alu_control = 1'b1;
            end
            OP_ADDI8: begin
                op_class   = CLS_ALU;
                imm_sel    = IMM_SEXT8;
                alu_b_sel  = ALUB_IMM;
                rm_from_rd = 1'b1;
            end
            OP_ADDU8: begin
                op_class   = CLS_ALU;
                imm_sel    = IMM_ZEXT8;
                alu_b_sel  = ALUB_IMM;
                rm_from_rd = 1'b1;
            end
            // MOVT merges imm8 with the low byte of Rd, so Rd is read on port A.
            OP_MOVT: begin
                op_class   = CLS_MOVT;
                imm_sel    = IMM_MOVT;
                wb_sel     = WB_IMM;
                rm_from_rd = 1'b1;
            end
            OP_CMP: begin
                op_class    = CLS_CMP;
                alu_control = 1'b1;
            end
            OP_LDR: begin
                op_class  = CLS_LDR;
                alu_b_sel = ALUB_IMM;
                wb_sel    = WB_MEM;
            end
            OP_STR: begin
                op_class   = CLS_STR;
                alu_b_sel  = ALUB_IMM;
                rn_from_rd = 1'b1;
            end
            OP_B, OP_BEQ, OP_BNE, OP_BLT: begin
                op_class = CLS_BR;
                imm_sel  = IMM_SEXT8;
            end
            OP_HALT: op_class = CLS_HALT;
            default: op_class = CLS_UNDEF;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer for the 16-bit RISC datapath: one FSM step per cycle,
// all datapath controls decoded from the current state and the latched instruction.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Instr,
    input  logic [3:0]  NZVC,
    input  logic        Mem_Ack,
    output logic        Mem_Req,
    output logic        Mem_Write_en,
    output logic        Addr_Sel,
    output logic        IR_Write_en,
    output logic        PC_Write_en,
    output logic        PC_Sel,
    output logic        RF_Write_en,
    output logic [1:0]  WB_Sel,
    output logic [2:0]  Rd_to_RF,
    output logic [2:0]  Rm_Rd_to_RF,
    output logic [2:0]  Rn_to_RF,
    output logic [1:0]  ALU_B_Sel,
    output logic        ALU_Control,
    output logic        ALUOut_CE,
    output logic [1:0]  Imm_Sel,
    output logic        Halted
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

    state_t                state_q;
    logic [3:0]            flags_q;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    op_class_t  op_class;
    logic [1:0] dec_imm_sel;
    logic [1:0] dec_wb_sel;
    logic [1:0] dec_alu_b_sel;
    logic       dec_alu_control;
    logic       rm_from_rd;
    logic       rn_from_rd;
    logic [1:0] br_cond;

    logic [2:0] rd_f;
    logic [2:0] rm_f;
    logic [2:0] rn_f;
    logic [2:0] rm_addr;
    logic [2:0] rn_addr;
    logic       taken;
    logic       unused_ok;

    instr_decoder u_dec (
        .opcode      (Instr[OPC_MSB:OPC_LSB]),
        .op_class    (op_class),
        .imm_sel     (dec_imm_sel),
        .wb_sel      (dec_wb_sel),
        .alu_b_sel   (dec_alu_b_sel),
        .alu_control (dec_alu_control),
        .rm_from_rd  (rm_from_rd),
        .rn_from_rd  (rn_from_rd),
        .br_cond     (br_cond)
    );

    assign rd_f    = Instr[RD_MSB:RD_LSB];
    assign rm_f    = Instr[RM_MSB:RM_LSB];
    assign rn_f    = Instr[RN_MSB:RN_LSB];
    assign rm_addr = rm_from_rd ? rd_f : rm_f;
    assign rn_addr = rn_from_rd ? rd_f : rn_f;

    // Immediate low bits and the carry flag have no role in sequencing.
    assign unused_ok = ^{Instr[RN_LSB-1:0], flags_q[FLAG_C]};

    // Branches resolve against flags captured by the last ALU/CMP, not the live ALU outputs.
    always_comb begin
        case (br_cond)
            BR_ALWAYS: taken = 1'b1;
            BR_EQ:     taken = flags_q[FLAG_Z];
            BR_NE:     taken = ~flags_q[FLAG_Z];
            BR_LT:     taken = flags_q[FLAG_N] ^ flags_q[FLAG_V];
            default:   taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            flags_q  <= '0;
            wait_cnt <= '0;
        end else begin
            wait_cnt <= '0;
            case (state_q)
                ST_FETCH: begin
                    if (Mem_Ack) begin
                        state_q <= ST_DECODE;
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state_q <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DECODE: begin
                    case (op_class)
                        CLS_BR:    state_q <= ST_BRANCH;
                        CLS_HALT:  state_q <= ST_HALT;
                        CLS_UNDEF: state_q <= ST_FETCH;
                        default:   state_q <= ST_EXEC;
                    endcase
                end
                ST_EXEC: begin
                    if (op_class == CLS_ALU || op_class == CLS_CMP) begin
                        flags_q <= NZVC;
                    end
                    case (op_class)
                        CLS_ALU, CLS_MOVT: state_q <= ST_WB;
                        CLS_LDR, CLS_STR:  state_q <= ST_MEM;
                        default:           state_q <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (Mem_Ack) begin
                        if (op_class == CLS_STR) begin
                            state_q <= ST_FETCH;
                        end else begin
                            state_q <= ST_WB;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        state_q <= ST_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WB:     state_q <= ST_FETCH;
                ST_BRANCH: state_q <= ST_FETCH;
                ST_HALT:   state_q <= ST_HALT;
                default:   state_q <= ST_FETCH;
            endcase
        end
    end

    // Output gating on rst lets a reset abort an in-flight memory request immediately.
    always_comb begin
        Mem_Req      = 1'b0;
        Mem_Write_en = 1'b0;
        Addr_Sel     = 1'b0;
        IR_Write_en  = 1'b0;
        PC_Write_en  = 1'b0;
        PC_Sel       = 1'b0;
        RF_Write_en  = 1'b0;
        WB_Sel       = WB_ALU;
        Rd_to_RF     = 3'd0;
        Rm_Rd_to_RF  = 3'd0;
        Rn_to_RF     = 3'd0;
        ALU_B_Sel    = ALUB_RF;
        ALU_Control  = 1'b0;
        ALUOut_CE    = 1'b0;
        Imm_Sel      = IMM_SEXT5;
        Halted       = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    Mem_Req     = 1'b1;
                    IR_Write_en = Mem_Ack;
                    PC_Write_en = Mem_Ack;
                end
                ST_DECODE: begin
                    Rm_Rd_to_RF = rm_addr;
                    Rn_to_RF    = rn_addr;
                    Imm_Sel     = dec_imm_sel;
                end
                ST_EXEC: begin
                    Rm_Rd_to_RF = rm_addr;
                    Rn_to_RF    = rn_addr;
                    Imm_Sel     = dec_imm_sel;
                    ALU_B_Sel   = dec_alu_b_sel;
                    ALU_Control = dec_alu_control;
                    ALUOut_CE   = 1'b1;
                end
                ST_MEM: begin
                    Rm_Rd_to_RF  = rm_addr;
                    Rn_to_RF     = rn_addr;
                    Imm_Sel      = dec_imm_sel;
                    Mem_Req      = 1'b1;
                    Addr_Sel     = 1'b1;
                    Mem_Write_en = (op_class == CLS_STR);
                end
                ST_WB: begin
                    Rm_Rd_to_RF = rm_addr;
                    Rn_to_RF    = rn_addr;
                    Imm_Sel     = dec_imm_sel;
                    RF_Write_en = 1'b1;
                    Rd_to_RF    = rd_f;
                    WB_Sel      = dec_wb_sel;
                end
                ST_BRANCH: begin
                    Imm_Sel     = IMM_SEXT8;
                    PC_Write_en = taken;
                    PC_Sel      = taken;
                end
                ST_HALT: Halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
